// File: rtl/uart_pkg.sv
// Shared constants for the UART command register file: frame field widths,
// register addresses, CTRL bit positions and FSM state encodings.
package uart_pkg;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 4;
  localparam int PWM_STEPS = 15;

  localparam logic [ADDR_W-1:0] ADDR_CTRL = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DUTY = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_ERR  = 3'd2;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_DIR   = 1;
  localparam int CTRL_BRAKE = 2;

  typedef enum logic {RSP_IDLE, RSP_PEND} rsp_state_t;
  typedef enum logic [1:0] {MOT_OFF, MOT_RUN, MOT_DEAD} mot_state_t;
endpackage

// File: rtl/motor_pwm.sv
// PWM generator: prescaler ticks a 15-step counter; output is high while
// the step is below the duty value.
module motor_pwm
  import uart_pkg::*;
#(
  parameter int PWM_PRESCALE = 3333
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [DATA_W-1:0] duty,
  output logic              pwm_on
);
  localparam int PS_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

  logic [PS_W-1:0] presc;
  logic [3:0]      step;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      step  <= '0;
    end else if (presc == PS_W'(PWM_PRESCALE - 1)) begin
      presc <= '0;
      step  <= (step == 4'(PWM_STEPS - 1)) ? 4'd0 : step + 4'd1;
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

  assign pwm_on = (step < duty);
endmodule

// File: rtl/uart_cmd_regfile.sv
// Register file driven by received UART frames, with a single-entry read
// response channel and an H-bridge motor controller with dead time.
module uart_cmd_regfile
  import uart_pkg::*;
#(
  parameter int PWM_PRESCALE = 3333,
  parameter int DEADTIME     = 500
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              frame_valid,
  input  logic              frame_rw,
  input  logic [ADDR_W-1:0] frame_addr,
  input  logic [DATA_W-1:0] frame_data,
  input  logic              frame_parity_err,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] tx_addr,
  output logic [DATA_W-1:0] tx_data,
  output logic              INA,
  output logic              INB
);
  localparam int DC_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  logic [2:0]        ctrl;
  logic [DATA_W-1:0] duty;
  logic [1:0]        parity_cnt;
  logic [1:0]        drop_cnt;
  logic [DATA_W-1:0] scratch [3:7];
  logic [DATA_W-1:0] rd_data;

  rsp_state_t rsp_state;
  mot_state_t mot_state;
  logic [DC_W-1:0] dead_cnt;
  logic            dir_q;
  logic            pwm_on;

  logic frame_ok, wr_en, rd_req, rd_accept, rd_drop;
  logic en, dir, brake, dir_toggle;

  assign frame_ok  = frame_valid && !frame_parity_err;
  assign wr_en     = frame_ok && !frame_rw;
  assign rd_req    = frame_ok && frame_rw;
  assign rd_accept = rd_req && ((rsp_state == RSP_IDLE) || tx_ready);
  assign rd_drop   = rd_req && !rd_accept;

  assign en         = ctrl[CTRL_EN];
  assign dir        = ctrl[CTRL_DIR];
  assign brake      = ctrl[CTRL_BRAKE];
  assign dir_toggle = (dir != dir_q);

  always_comb begin
    rd_data = '0;
    case (frame_addr)
      ADDR_CTRL: rd_data = {1'b0, ctrl};
      ADDR_DUTY: rd_data = duty;
      ADDR_ERR:  rd_data = {drop_cnt, parity_cnt};
      default:   rd_data = scratch[frame_addr];
    endcase
  end

  // Register map; the two ERR fields advance independently so no count is lost
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      ctrl       <= '0;
      duty       <= '0;
      parity_cnt <= '0;
      drop_cnt   <= '0;
      for (int i = 3; i <= 7; i++) scratch[i] <= '0;
    end else begin
      if (frame_valid && frame_parity_err) parity_cnt <= sat_inc(parity_cnt);
      if (rd_drop) drop_cnt <= sat_inc(drop_cnt);
      if (wr_en) begin
        case (frame_addr)
          ADDR_CTRL: ctrl <= frame_data[2:0];
          ADDR_DUTY: duty <= frame_data;
          ADDR_ERR: begin
            parity_cnt <= '0;
            drop_cnt   <= '0;
          end
          default:   scratch[frame_addr] <= frame_data;
        endcase
      end
    end
  end

  // Response channel: data is snapshotted when the READ is accepted
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      rsp_state <= RSP_IDLE;
      tx_valid  <= 1'b0;
      tx_addr   <= '0;
      tx_data   <= '0;
    end else begin
      case (rsp_state)
        RSP_IDLE: begin
          if (rd_accept) begin
            tx_addr   <= frame_addr;
            tx_data   <= rd_data;
            tx_valid  <= 1'b1;
            rsp_state <= RSP_PEND;
          end
        end
        RSP_PEND: begin
          if (rd_accept) begin
            tx_addr <= frame_addr;
            tx_data <= rd_data;
          end else if (tx_ready) begin
            tx_valid  <= 1'b0;
            rsp_state <= RSP_IDLE;
          end
        end
        default: begin
          tx_valid  <= 1'b0;
          rsp_state <= RSP_IDLE;
        end
      endcase
    end
  end

  motor_pwm #(.PWM_PRESCALE(PWM_PRESCALE)) u_pwm (
    .clk_in (clk_in),
    .rst    (rst),
    .duty   (duty),
    .pwm_on (pwm_on)
  );

  // Motor FSM; pins follow dir_q so a new direction is never driven before dead time
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      mot_state <= MOT_OFF;
      dead_cnt  <= '0;
      dir_q     <= 1'b0;
      INA       <= 1'b0;
      INB       <= 1'b0;
    end else begin
      dir_q <= dir;
      case (mot_state)
        MOT_OFF: if (en) mot_state <= MOT_RUN;
        MOT_RUN: begin
          if (!en) mot_state <= MOT_OFF;
          else if (dir_toggle) begin
            mot_state <= MOT_DEAD;
            dead_cnt  <= '0;
          end
        end
        MOT_DEAD: begin
          if (!en) mot_state <= MOT_OFF;
          else if (dir_toggle) dead_cnt <= '0;
          else if (dead_cnt == DC_W'(DEADTIME - 1)) mot_state <= MOT_RUN;
          else dead_cnt <= dead_cnt + DC_W'(1);
        end
        default: mot_state <= MOT_OFF;
      endcase

      if (en && brake) begin
        INA <= 1'b1;
        INB <= 1'b1;
      end else if (mot_state == MOT_RUN) begin
        INA <= pwm_on && !dir_q;
        INB <= pwm_on && dir_q;
      end else begin
        INA <= 1'b0;
        INB <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_regfile.sv
// Bench for uart_cmd_regfile: directed motor scenarios plus randomized frame
// traffic compared against a transaction-level register/response model.
module tb_uart_cmd_regfile;
  localparam int P  = 4;
  localparam int DT = 500;
  localparam int PERIOD = 15 * P;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       frame_valid = 1'b0, frame_rw = 1'b0, frame_parity_err = 1'b0;
  logic [2:0] frame_addr = '0;
  logic [3:0] frame_data = '0;
  logic       tx_ready = 1'b0;
  logic       tx_valid;
  logic [2:0] tx_addr;
  logic [3:0] tx_data;
  logic       INA, INB;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_reg [8];
  int m_perr, m_drop, m_pa, m_pd;
  bit m_pend;

  uart_cmd_regfile #(.PWM_PRESCALE(P), .DEADTIME(DT)) dut (
    .clk_in           (clk_in),
    .rst              (rst),
    .frame_valid      (frame_valid),
    .frame_rw         (frame_rw),
    .frame_addr       (frame_addr),
    .frame_data       (frame_data),
    .frame_parity_err (frame_parity_err),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_addr          (tx_addr),
    .tx_data          (tx_data),
    .INA              (INA),
    .INB              (INB)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v >= 3) ? 3 : v + 1;
  endfunction

  function automatic int m_read(input int a);
    if (a == 2) return m_drop * 4 + m_perr;
    return m_reg[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    m_perr = 0; m_drop = 0; m_pend = 0; m_pa = 0; m_pd = 0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then check.
  task automatic tick();
    bit was_pend, acc;
    int a, d;
    @(posedge clk_in);
    was_pend = m_pend;
    acc = 0;
    a = int'(frame_addr);
    d = int'(frame_data);
    if (frame_valid) begin
      if (frame_parity_err) m_perr = sat3(m_perr);
      else if (frame_rw) begin
        if (!was_pend || tx_ready) begin
          m_pa = a; m_pd = m_read(a); acc = 1;
        end else m_drop = sat3(m_drop);
      end else begin
        if (a == 0) m_reg[0] = d % 8;
        else if (a == 2) begin m_perr = 0; m_drop = 0; end
        else m_reg[a] = d;
      end
    end
    if (acc) m_pend = 1;
    else if (was_pend && tx_ready) m_pend = 0;
    #1;
    chk("tx_valid", tx_valid, m_pend);
    if (m_pend) begin
      chk("tx_addr", tx_addr, m_pa);
      chk("tx_data", tx_data, m_pd);
    end
  endtask

  task automatic send(input bit rw, input int a, input int d, input bit pe);
    frame_valid = 1'b1; frame_rw = rw; frame_parity_err = pe;
    frame_addr = a[2:0]; frame_data = d[3:0];
    tick();
    frame_valid = 1'b0; frame_parity_err = 1'b0;
  endtask

  task automatic read_reg(input int a, output int got);
    send(1'b1, a, 0, 1'b0);
    got = int'(tx_data);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic count_pins(input int n, output int na, output int nb);
    na = 0; nb = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      na += int'(INA);
      nb += int'(INB);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int got, na, nb, viol;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_addr", tx_addr, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_INA", INA, 0);
    chk("rst_INB", INB, 0);
    rst = 1'b1;
    idle(2);

    // Parity-error frame is ignored but counted
    send(1'b0, 0, 1, 1'b1);
    read_reg(0, got); chk("perr_ctrl", got, 0);
    read_reg(2, got); chk("perr_err", got, 1);
    count_pins(20, na, nb);
    chk("perr_motor", na + nb, 0);

    // Pending response held, second READ dropped
    send(1'b0, 2, 0, 1'b0);
    send(1'b0, 3, 9, 1'b0);
    send(1'b1, 3, 0, 1'b0);
    idle(10);
    chk("hold_addr", tx_addr, 3);
    chk("hold_data", tx_data, 9);
    send(1'b0, 3, 2, 1'b0);
    send(1'b1, 5, 0, 1'b0);
    chk("drop_keep_data", tx_data, 9);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    read_reg(2, got); chk("drop_err", got, 4);

    // Forward PWM at duty 7
    send(1'b0, 1, 7, 1'b0);
    send(1'b0, 0, 1, 1'b0);
    idle(3);
    count_pins(PERIOD, na, nb);
    chk("fwd_INA_high", na, 7 * P);
    chk("fwd_INB_high", nb, 0);

    // Direction change: dead time then reverse PWM
    send(1'b0, 0, 3, 1'b0);
    tick();
    viol = 0;
    for (int i = 0; i < DT; i++) begin
      tick();
      if (INA || INB) viol++;
    end
    chk("dead_low", viol, 0);
    idle(3);
    count_pins(PERIOD, na, nb);
    chk("rev_INA_high", na, 0);
    chk("rev_INB_high", nb, 7 * P);

    // Duty extremes
    send(1'b0, 0, 1, 1'b0);
    send(1'b0, 1, 0, 1'b0);
    idle(DT + 5);
    count_pins(2 * PERIOD, na, nb);
    chk("duty0_INA", na, 0);
    chk("duty0_INB", nb, 0);
    send(1'b0, 1, 15, 1'b0);
    idle(3);
    count_pins(2 * PERIOD, na, nb);
    chk("duty15_INA", na, 2 * PERIOD);
    chk("duty15_INB", nb, 0);

    // Randomized frame traffic
    for (int i = 0; i < 400; i++) begin
      tx_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) begin
        frame_valid = 1'b1;
        frame_rw = ($urandom_range(0, 1) == 1);
        frame_parity_err = ($urandom_range(0, 7) == 0);
        frame_addr = 3'($urandom_range(0, 7));
        frame_data = 4'($urandom_range(0, 15));
      end
      tick();
      frame_valid = 1'b0; frame_parity_err = 1'b0;
    end
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;

    // Brake, then asynchronous reset with a response pending
    send(1'b0, 0, 5, 1'b0);
    idle(3);
    chk("brake_INA", INA, 1);
    chk("brake_INB", INB, 1);
    send(1'b1, 4, 0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_INA", INA, 0);
    chk("arst_INB", INB, 0);
    chk("arst_tx_valid", tx_valid, 0);
    @(posedge clk_in);
    #1 rst = 1'b1;
    model_reset();
    for (int a = 0; a < 8; a++) begin
      read_reg(a, got);
      chk("arst_reg", got, 0);
    end
    count_pins(20, na, nb);
    chk("arst_motor", na + nb, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_cmd_regfile.md
UART_CMD_REGFILE -- requirements
Module: uart_cmd_regfile

Interface
REQ-001 SHALL have parameter PWM_PRESCALE, default 3333, clk_in cycles per PWM step; the PWM period is 15 steps, about 1 kHz at 50 MHz.
REQ-002 SHALL have parameter DEADTIME, default 500, clk_in cycles both motor outputs are held low on a direction change.
REQ-003 SHALL have ports: clk_in input 1, single system clock (50 MHz); rst input 1, reset, asynchronous and active-low.
REQ-004 SHALL have ports: frame_valid input 1, one-cycle pulse when the upstream UART receiver completes a frame; frame_rw input 1, 1=READ, 0=WRITE; frame_addr input 3, register address; frame_data input 4, write data; frame_parity_err input 1, received parity mismatch.
REQ-005 SHALL have ports: tx_valid output 1, response pending; tx_ready input 1, transmitter accepts; tx_addr output 3, echoed address; tx_data output 4, read data.
REQ-006 SHALL have ports: INA output 1 and INB output 1, H-bridge motor driver inputs.

Function
REQ-007 SHALL sample the frame_* inputs only in a cycle where frame_valid=1.
REQ-008 SHALL ignore the frame contents when frame_parity_err=1, and SHALL increment ERR[1:0] (saturating at 3).
REQ-009 SHALL provide the register map: 0 CTRL {bit0 enable, bit1 dir, bit2 brake, bit3 reserved}; 1 DUTY; 2 ERR (read-only, {drop_cnt[3:2], parity_cnt[1:0]}); 3-7 SCRATCH.
REQ-010 SHALL update the addressed register the next cycle on a WRITE; WRITE to addr 2 clears ERR to 0; CTRL bit3 always reads 0.
REQ-011 SHALL run the response FSM with states RSP_IDLE and RSP_PEND; a READ arriving in RSP_IDLE loads tx_addr and tx_data and enters RSP_PEND with tx_valid=1 on the next cycle.
REQ-012 SHALL hold tx_valid, tx_addr and tx_data stable in RSP_PEND until a cycle with tx_ready=1, then return to RSP_IDLE.
REQ-013 SHALL drop a READ that arrives in RSP_PEND and increment ERR[3:2] (saturating at 3); if it arrives in the same cycle as tx_ready=1, the READ SHALL be accepted instead.
REQ-014 SHALL capture READ data as the register value at the frame_valid cycle; a WRITE to that register later SHALL NOT alter a pending response.
REQ-015 SHALL, when a parity error and an ERR counter increment coincide, apply both increments with no lost counts.
REQ-016 SHALL generate PWM from a prescaler (0..PWM_PRESCALE-1) and a step counter (0..14) that wraps; pwm_on = (step < DUTY), so DUTY=0 is always off and DUTY>=15 is always on.
REQ-017 SHALL run the motor FSM with states OFF, RUN and DEAD.
  - OFF: INA=INB=0.
  - RUN: dir=0 gives INA=pwm_on, INB=0; dir=1 gives INA=0, INB=pwm_on.
  - DEAD: INA=INB=0 for DEADTIME cycles, then RUN.
REQ-018 SHALL make motor FSM transitions as follows: OFF->RUN when enable=1; RUN->OFF when enable=0; RUN->DEAD on a dir toggle; DEAD->OFF when enable=0 (this takes priority); a dir toggle during DEAD SHALL restart the DEAD count.
REQ-019 SHALL force INA=INB=1 whenever brake=1 and enable=1, regardless of FSM state and dir; the FSM SHALL continue to track state underneath.
REQ-020 SHALL register INA and INB, giving exactly one cycle of latency from the state and PWM change to the pin.

Reset
REQ-021 SHALL, on rst=0, asynchronously clear all registers to 0, set the response FSM to RSP_IDLE, set the motor FSM to OFF, and clear the prescaler, step and DEAD counters.
REQ-022 SHALL hold tx_valid=0, tx_addr=0, tx_data=0, INA=0 and INB=0 while in reset.
REQ-023 SHALL discard a pending response and drive both motor pins low immediately on reset mid-operation, with no glitch to 1.
REQ-024 SHALL resume operation on the first clk_in edge after rst rises.

Structure
REQ-025 SHALL place the register-address constants, CTRL bit indices and FSM state encodings in the shared package uart_pkg, alongside the frame-field widths used by the receiver.
REQ-026 SHALL implement the prescaler, step counter and comparator as the sub-module motor_pwm (inputs clk_in, rst, duty[3:0]; output pwm_on).

Verification
REQ-027 SHALL cover: WRITE addr1=0x7, then WRITE addr0=0x1 -> INA high for 7/15 of each period and INB=0.
REQ-028 SHALL cover: WRITE addr0=0x3 while RUN -> INA=INB=0 for 500 cycles, then INB carries the PWM.
REQ-029 SHALL cover: READ addr3 with SCRATCH=0x9 and tx_ready held 0 for 10 cycles -> tx_valid held with tx_addr=3 and tx_data=0x9; a second READ is dropped and ERR reads 0x4.
REQ-030 SHALL cover: frame with frame_parity_err=1, WRITE addr0=0x1 -> CTRL unchanged, ERR[1:0]=1, motor stays OFF.
REQ-031 SHALL cover: WRITE addr0=0x5 -> INA=INB=1; then rst asserted mid-PWM -> INA=INB=0 asynchronously and all registers read 0.
REQ-032 SHALL cover: DUTY=0 and DUTY=15 with enable=1 -> output constant low and constant high respectively across two full PWM periods.
